// File: rtl/ht_cmd_arb_mc.sv
// Round-robin command arbiter in front of the in-order hash table pipeline.
// A tag FIFO steers each pipeline result back to the channel that issued its command.
module ht_cmd_arb_mc #(
  parameter int CHANNELS        = 4,
  parameter int CMD_W           = 50,
  parameter int RES_W           = 53,
  parameter int MAX_OUTSTANDING = 16
) (
  input  logic                                 clk_i,
  input  logic                                 rst_n_i,
  input  logic [CHANNELS*CMD_W-1:0]            ch_cmd_i,
  input  logic [CHANNELS-1:0]                  ch_cmd_valid_i,
  output logic [CHANNELS-1:0]                  ch_cmd_ready_o,
  output logic [CHANNELS*RES_W-1:0]            ch_res_o,
  output logic [CHANNELS-1:0]                  ch_res_valid_o,
  input  logic [CHANNELS-1:0]                  ch_res_ready_i,
  output logic [CMD_W-1:0]                     ht_cmd_o,
  output logic                                 ht_cmd_valid_o,
  input  logic                                 ht_cmd_ready_i,
  input  logic [RES_W-1:0]                     ht_res_i,
  input  logic                                 ht_res_valid_i,
  output logic                                 ht_res_ready_o,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o,
  output logic                                 err_orphan_o
);

  localparam int TAG_W = $clog2(CHANNELS);
  localparam int PTR_W = $clog2(MAX_OUTSTANDING);
  localparam int CNT_W = $clog2(MAX_OUTSTANDING+1);

  logic [TAG_W-1:0] rrPtr_q, rrPtr_d;
  logic [CMD_W-1:0] cmd_q, cmd_d;
  logic             cmdValid_q, cmdValid_d;
  logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             errOrphan_q, errOrphan_d;
  logic [TAG_W-1:0] tagMem_q [MAX_OUTSTANDING];

  logic [TAG_W-1:0] grant;
  logic             grantFound;
  logic [TAG_W:0]   scanSum;
  logic [TAG_W-1:0] scanIdx;
  logic [CMD_W-1:0] grantCmd;
  logic             fifoFull;
  logic             fifoEmpty;
  logic             load;
  logic             push;
  logic             pop;
  logic [TAG_W-1:0] head;
  logic             resReady;

  assign fifoFull  = (count_q == CNT_W'(MAX_OUTSTANDING));
  assign fifoEmpty = (count_q == '0);

  // First valid channel at or above the RR pointer, wrapping past the top channel.
  always_comb begin
    grant      = '0;
    grantFound = 1'b0;
    scanSum    = '0;
    scanIdx    = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      scanSum = {1'b0, rrPtr_q} + (TAG_W+1)'(i);
      if (scanSum >= (TAG_W+1)'(CHANNELS)) begin
        scanSum = scanSum - (TAG_W+1)'(CHANNELS);
      end
      scanIdx = scanSum[TAG_W-1:0];
      if (!grantFound && ch_cmd_valid_i[scanIdx]) begin
        grantFound = 1'b1;
        grant      = scanIdx;
      end
    end
  end

  always_comb begin
    grantCmd = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (grant == TAG_W'(c)) begin
        grantCmd = ch_cmd_i[c*CMD_W +: CMD_W];
      end
    end
  end

  // grantFound is equivalent to |ch_cmd_valid_i.
  assign load = (!cmdValid_q || ht_cmd_ready_i) && !fifoFull && grantFound;
  assign push = load;
  assign pop  = ht_res_valid_i && resReady && !fifoEmpty;

  always_comb begin
    ch_cmd_ready_o        = '0;
    ch_cmd_ready_o[grant] = load;
  end

  always_comb begin
    cmd_d      = cmd_q;
    cmdValid_d = cmdValid_q;
    rrPtr_d    = rrPtr_q;
    if (load) begin
      cmd_d      = grantCmd;
      cmdValid_d = 1'b1;
      if (grant == TAG_W'(CHANNELS-1)) begin
        rrPtr_d = '0;
      end else begin
        rrPtr_d = grant + TAG_W'(1);
      end
    end else if (ht_cmd_ready_i) begin
      cmdValid_d = 1'b0;
    end
  end

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (push) begin
      wrPtr_d = wrPtr_q + PTR_W'(1);
    end
    if (pop) begin
      rdPtr_d = rdPtr_q + PTR_W'(1);
    end
    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !push) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  assign errOrphan_d = errOrphan_q | (ht_res_valid_i && fifoEmpty);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rrPtr_q     <= '0;
      cmd_q       <= '0;
      cmdValid_q  <= 1'b0;
      wrPtr_q     <= '0;
      rdPtr_q     <= '0;
      count_q     <= '0;
      errOrphan_q <= 1'b0;
    end else begin
      rrPtr_q     <= rrPtr_d;
      cmd_q       <= cmd_d;
      cmdValid_q  <= cmdValid_d;
      wrPtr_q     <= wrPtr_d;
      rdPtr_q     <= rdPtr_d;
      count_q     <= count_d;
      errOrphan_q <= errOrphan_d;
    end
  end

  // Tag storage needs no reset: the pointers and count alone decide what is live.
  always_ff @(posedge clk_i) begin
    if (push) begin
      tagMem_q[wrPtr_q] <= grant;
    end
  end

  assign head = tagMem_q[rdPtr_q];

  // With no tag outstanding the result is an orphan: accept and drop it.
  always_comb begin
    ch_res_valid_o = '0;
    resReady       = 1'b1;
    if (!fifoEmpty) begin
      ch_res_valid_o[head] = ht_res_valid_i;
      resReady             = ch_res_ready_i[head];
    end
  end

  assign ht_res_ready_o = resReady;
  assign ch_res_o       = {CHANNELS{ht_res_i}};
  assign ht_cmd_o       = cmd_q;
  assign ht_cmd_valid_o = cmdValid_q;
  assign outstanding_o  = count_q;
  assign err_orphan_o   = errOrphan_q;

endmodule

// File: tb/tb_ht_cmd_arb_mc.sv
// Self-checking bench for ht_cmd_arb_mc: a reference model with command and tag
// scoreboards predicts grants, pipeline commands and result routing every cycle.
module tb_ht_cmd_arb_mc;

  localparam int CHANNELS = 4;
  localparam int CMD_W    = 50;
  localparam int RES_W    = 53;
  localparam int MAX_OUT  = 16;
  localparam int CNT_W    = $clog2(MAX_OUT+1);

  logic                          clk_i = 1'b0;
  logic                          rst_n_i;
  logic [CHANNELS*CMD_W-1:0]     ch_cmd_i;
  logic [CHANNELS-1:0]           ch_cmd_valid_i;
  logic [CHANNELS-1:0]           ch_cmd_ready_o;
  logic [CHANNELS*RES_W-1:0]     ch_res_o;
  logic [CHANNELS-1:0]           ch_res_valid_o;
  logic [CHANNELS-1:0]           ch_res_ready_i;
  logic [CMD_W-1:0]              ht_cmd_o;
  logic                          ht_cmd_valid_o;
  logic                          ht_cmd_ready_i;
  logic [RES_W-1:0]              ht_res_i;
  logic                          ht_res_valid_i;
  logic                          ht_res_ready_o;
  logic [CNT_W-1:0]              outstanding_o;
  logic                          err_orphan_o;

  ht_cmd_arb_mc #(
    .CHANNELS(CHANNELS), .CMD_W(CMD_W), .RES_W(RES_W), .MAX_OUTSTANDING(MAX_OUT)
  ) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .ch_cmd_i(ch_cmd_i), .ch_cmd_valid_i(ch_cmd_valid_i), .ch_cmd_ready_o(ch_cmd_ready_o),
    .ch_res_o(ch_res_o), .ch_res_valid_o(ch_res_valid_o), .ch_res_ready_i(ch_res_ready_i),
    .ht_cmd_o(ht_cmd_o), .ht_cmd_valid_o(ht_cmd_valid_o), .ht_cmd_ready_i(ht_cmd_ready_i),
    .ht_res_i(ht_res_i), .ht_res_valid_i(ht_res_valid_i), .ht_res_ready_o(ht_res_ready_o),
    .outstanding_o(outstanding_o), .err_orphan_o(err_orphan_o)
  );

  always #5 clk_i = ~clk_i;

  int checkCount = 0;
  int passCount  = 0;

  // Reference model state: RR pointer, command register queue, tag queue, sticky error.
  int               mRr = 0;
  int               mTags[$];
  logic [CMD_W-1:0] expCmdQ[$];
  bit               mErr = 1'b0;

  bit                  eLoad;
  int                  eGrant;
  logic [CHANNELS-1:0] eReady;
  logic [CHANNELS-1:0] eResValid;
  logic                eResReady;
  bit                  ePop;
  bit                  eOrphan;

  function automatic logic [CMD_W-1:0] randCmd();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[CMD_W-1:0];
  endfunction

  function automatic logic [RES_W-1:0] randRes();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[RES_W-1:0];
  endfunction

  task automatic predictNext();
    bit full;
    bit cmdValid;
    int idx;
    full     = (mTags.size() >= MAX_OUT);
    cmdValid = (expCmdQ.size() != 0);
    eLoad    = 1'b0;
    eGrant   = 0;
    eReady   = '0;
    if ((!cmdValid || ht_cmd_ready_i) && !full) begin
      for (int i = 0; i < CHANNELS; i++) begin
        idx = (mRr + i) % CHANNELS;
        if (!eLoad && ch_cmd_valid_i[idx]) begin
          eLoad  = 1'b1;
          eGrant = idx;
        end
      end
    end
    if (eLoad) eReady[eGrant] = 1'b1;
    eResValid = '0;
    if (mTags.size() == 0) begin
      eResReady = 1'b1;
      ePop      = 1'b0;
      eOrphan   = ht_res_valid_i;
    end else begin
      eResValid[mTags[0]] = ht_res_valid_i;
      eResReady           = ch_res_ready_i[mTags[0]];
      ePop                = ht_res_valid_i && eResReady;
      eOrphan             = 1'b0;
    end
  endtask

  task automatic applyStimulus(input logic [CHANNELS-1:0] vld,
                               input logic [CHANNELS*CMD_W-1:0] cmds,
                               input logic rdy, input logic resV,
                               input logic [RES_W-1:0] resD,
                               input logic [CHANNELS-1:0] resR);
    @(negedge clk_i);
    ch_cmd_valid_i = vld;
    ch_cmd_i       = cmds;
    ht_cmd_ready_i = rdy;
    ht_res_valid_i = resV;
    ht_res_i       = resD;
    ch_res_ready_i = resR;
    #1;
    predictNext();
  endtask

  task automatic advanceCycle();
    @(posedge clk_i);
    if (expCmdQ.size() != 0 && ht_cmd_ready_i) void'(expCmdQ.pop_front());
    if (ePop) void'(mTags.pop_front());
    if (eLoad) begin
      expCmdQ.push_back(ch_cmd_i[eGrant*CMD_W +: CMD_W]);
      mTags.push_back(eGrant);
      mRr = (eGrant + 1) % CHANNELS;
    end
    if (eOrphan) mErr = 1'b1;
  endtask

  task automatic doReset();
    @(negedge clk_i);
    ch_cmd_valid_i = '0;
    ch_cmd_i       = '0;
    ht_cmd_ready_i = 1'b1;
    ht_res_valid_i = 1'b0;
    ht_res_i       = '0;
    ch_res_ready_i = '1;
    rst_n_i        = 1'b0;
    repeat (2) @(negedge clk_i);
    mTags.delete();
    expCmdQ.delete();
    mRr  = 0;
    mErr = 1'b0;
    rst_n_i = 1'b1;
  endtask

  task automatic test_reset();
    rst_n_i        = 1'b0;
    ch_cmd_valid_i = '0;
    ch_cmd_i       = '0;
    ht_cmd_ready_i = 1'b1;
    ht_res_valid_i = 1'b0;
    ht_res_i       = '0;
    ch_res_ready_i = '1;
    #2;
    checkCount++;
    if (ht_cmd_valid_o !== 1'b0) $display("[TB] FAIL reset_cmd_valid: got %b expected 0", ht_cmd_valid_o);
    else passCount++;
    checkCount++;
    if (ht_cmd_o !== '0) $display("[TB] FAIL reset_cmd: got %h expected 0", ht_cmd_o);
    else passCount++;
    checkCount++;
    if (outstanding_o !== '0) $display("[TB] FAIL reset_outstanding: got %0d expected 0", outstanding_o);
    else passCount++;
    checkCount++;
    if (err_orphan_o !== 1'b0) $display("[TB] FAIL reset_err: got %b expected 0", err_orphan_o);
    else passCount++;
    @(negedge clk_i);
    rst_n_i = 1'b1;
  endtask

  task automatic test_single_channel();
    logic [CMD_W-1:0]          cmds [3];
    logic [CHANNELS*CMD_W-1:0] vec;
    logic [RES_W-1:0]          res;
    doReset();
    for (int k = 0; k < 3; k++) cmds[k] = randCmd();
    for (int k = 0; k < 3; k++) begin
      vec = '0;
      vec[2*CMD_W +: CMD_W] = cmds[k];
      applyStimulus(4'b0100, vec, 1'b1, 1'b0, '0, '1);
      checkCount++;
      if (ch_cmd_ready_o !== 4'b0100) $display("[TB] FAIL single_ready %0d: got %b expected 0100", k, ch_cmd_ready_o);
      else passCount++;
      if (k > 0) begin
        checkCount++;
        if (ht_cmd_valid_o !== 1'b1 || ht_cmd_o !== cmds[k-1])
          $display("[TB] FAIL single_cmd %0d: got v=%b %h expected v=1 %h", k, ht_cmd_valid_o, ht_cmd_o, cmds[k-1]);
        else passCount++;
      end
      advanceCycle();
    end
    applyStimulus('0, '0, 1'b1, 1'b0, '0, '1);
    checkCount++;
    if (ht_cmd_valid_o !== 1'b1 || ht_cmd_o !== cmds[2] || outstanding_o !== CNT_W'(3))
      $display("[TB] FAIL single_last: got v=%b %h out=%0d expected v=1 %h out=3", ht_cmd_valid_o, ht_cmd_o, outstanding_o, cmds[2]);
    else passCount++;
    advanceCycle();
    applyStimulus('0, '0, 1'b1, 1'b0, '0, '1);
    checkCount++;
    if (ht_cmd_valid_o !== 1'b0 || outstanding_o !== CNT_W'(3))
      $display("[TB] FAIL single_drain: got v=%b out=%0d expected v=0 out=3", ht_cmd_valid_o, outstanding_o);
    else passCount++;
    advanceCycle();
    for (int k = 0; k < 3; k++) begin
      res = randRes();
      applyStimulus('0, '0, 1'b1, 1'b1, res, '1);
      checkCount++;
      if (ch_res_valid_o !== 4'b0100 || ht_res_ready_o !== 1'b1)
        $display("[TB] FAIL single_res_route %0d: got valid=%b ready=%b expected 0100 1", k, ch_res_valid_o, ht_res_ready_o);
      else passCount++;
      checkCount++;
      if (ch_res_o[2*RES_W +: RES_W] !== res || ch_res_o[0 +: RES_W] !== res)
        $display("[TB] FAIL single_res_data %0d: got %h/%h expected %h", k, ch_res_o[2*RES_W +: RES_W], ch_res_o[0 +: RES_W], res);
      else passCount++;
      advanceCycle();
    end
    applyStimulus('0, '0, 1'b1, 1'b0, '0, '1);
    checkCount++;
    if (outstanding_o !== '0) $display("[TB] FAIL single_end_outstanding: got %0d expected 0", outstanding_o);
    else passCount++;
    advanceCycle();
  endtask

  task automatic test_round_robin();
    logic [CHANNELS*CMD_W-1:0] vec;
    int                        grants [CHANNELS];
    doReset();
    for (int c = 0; c < CHANNELS; c++) grants[c] = 0;
    for (int i = 0; i < 8; i++) begin
      for (int c = 0; c < CHANNELS; c++) vec[c*CMD_W +: CMD_W] = randCmd();
      applyStimulus(4'b1111, vec, 1'b1, 1'b0, '0, '1);
      checkCount++;
      if (ch_cmd_ready_o !== (CHANNELS'(1) << (i % CHANNELS)))
        $display("[TB] FAIL rr_grant %0d: got %b expected %b", i, ch_cmd_ready_o, CHANNELS'(1) << (i % CHANNELS));
      else passCount++;
      if (expCmdQ.size() != 0) begin
        checkCount++;
        if (ht_cmd_valid_o !== 1'b1 || ht_cmd_o !== expCmdQ[0])
          $display("[TB] FAIL rr_cmd %0d: got v=%b %h expected v=1 %h", i, ht_cmd_valid_o, ht_cmd_o, expCmdQ[0]);
        else passCount++;
      end
      for (int c = 0; c < CHANNELS; c++) if (ch_cmd_ready_o[c] === 1'b1) grants[c]++;
      advanceCycle();
    end
    for (int c = 0; c < CHANNELS; c++) begin
      checkCount++;
      if (grants[c] != 2) $display("[TB] FAIL rr_share ch%0d: got %0d expected 2", c, grants[c]);
      else passCount++;
    end
    for (int i = 0; i < 8; i++) begin
      applyStimulus('0, '0, 1'b1, 1'b1, randRes(), '1);
      checkCount++;
      if (ch_res_valid_o !== (CHANNELS'(1) << (i % CHANNELS)) || ch_res_valid_o !== eResValid)
        $display("[TB] FAIL rr_res_route %0d: got %b expected %b", i, ch_res_valid_o, CHANNELS'(1) << (i % CHANNELS));
      else passCount++;
      advanceCycle();
    end
  endtask

  task automatic test_fifo_full();
    logic [CHANNELS*CMD_W-1:0] vec;
    int                        accepted;
    doReset();
    accepted = 0;
    for (int i = 0; i < 20; i++) begin
      vec = '0;
      vec[1*CMD_W +: CMD_W] = randCmd();
      applyStimulus(4'b0010, vec, 1'b1, 1'b0, '0, '1);
      checkCount++;
      if (ch_cmd_ready_o !== eReady) $display("[TB] FAIL full_ready %0d: got %b expected %b", i, ch_cmd_ready_o, eReady);
      else passCount++;
      if (ch_cmd_ready_o[1] === 1'b1) accepted++;
      advanceCycle();
    end
    checkCount++;
    if (accepted != 16) $display("[TB] FAIL full_accepted: got %0d expected 16", accepted);
    else passCount++;
    vec[1*CMD_W +: CMD_W] = randCmd();
    applyStimulus(4'b0010, vec, 1'b1, 1'b1, randRes(), '1);
    checkCount++;
    if (outstanding_o !== CNT_W'(16) || ch_cmd_ready_o !== 4'b0000 || ht_res_ready_o !== 1'b1 || ch_res_valid_o !== 4'b0010)
      $display("[TB] FAIL full_pop_cycle: got out=%0d rdy=%b rr=%b rv=%b expected 16 0000 1 0010",
               outstanding_o, ch_cmd_ready_o, ht_res_ready_o, ch_res_valid_o);
    else passCount++;
    advanceCycle();
    applyStimulus(4'b0010, vec, 1'b1, 1'b0, '0, '1);
    checkCount++;
    if (ch_cmd_ready_o !== 4'b0010 || outstanding_o !== CNT_W'(15))
      $display("[TB] FAIL full_refill: got rdy=%b out=%0d expected 0010 15", ch_cmd_ready_o, outstanding_o);
    else passCount++;
    advanceCycle();
    applyStimulus(4'b0010, vec, 1'b1, 1'b0, '0, '1);
    checkCount++;
    if (ch_cmd_ready_o !== 4'b0000 || outstanding_o !== CNT_W'(16))
      $display("[TB] FAIL full_again: got rdy=%b out=%0d expected 0000 16", ch_cmd_ready_o, outstanding_o);
    else passCount++;
    advanceCycle();
  endtask

  task automatic test_stall();
    logic [CMD_W-1:0]          cmdX;
    logic [CMD_W-1:0]          cmdY;
    logic [CHANNELS*CMD_W-1:0] vec;
    doReset();
    cmdX = randCmd();
    cmdY = randCmd();
    vec = '0;
    vec[0 +: CMD_W] = cmdX;
    applyStimulus(4'b0001, vec, 1'b1, 1'b0, '0, '1);
    advanceCycle();
    vec = '0;
    vec[3*CMD_W +: CMD_W] = cmdY;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(4'b1000, vec, 1'b0, 1'b0, '0, '1);
      checkCount++;
      if (ht_cmd_valid_o !== 1'b1 || ht_cmd_o !== cmdX || ch_cmd_ready_o !== 4'b0000 || outstanding_o !== CNT_W'(1))
        $display("[TB] FAIL stall_hold %0d: got v=%b %h rdy=%b out=%0d expected v=1 %h 0000 1",
                 i, ht_cmd_valid_o, ht_cmd_o, ch_cmd_ready_o, outstanding_o, cmdX);
      else passCount++;
      advanceCycle();
    end
    applyStimulus(4'b1000, vec, 1'b1, 1'b0, '0, '1);
    checkCount++;
    if (ch_cmd_ready_o !== 4'b1000) $display("[TB] FAIL stall_release: got %b expected 1000", ch_cmd_ready_o);
    else passCount++;
    advanceCycle();
    applyStimulus('0, '0, 1'b1, 1'b0, '0, '1);
    checkCount++;
    if (ht_cmd_o !== cmdY || outstanding_o !== CNT_W'(2))
      $display("[TB] FAIL stall_next: got %h out=%0d expected %h 2", ht_cmd_o, outstanding_o, cmdY);
    else passCount++;
    advanceCycle();
  endtask

  task automatic test_res_backpressure();
    logic [CHANNELS*CMD_W-1:0] vec;
    doReset();
    for (int c = 0; c < CHANNELS; c++) vec[c*CMD_W +: CMD_W] = randCmd();
    applyStimulus(4'b0010, vec, 1'b1, 1'b0, '0, '1);
    advanceCycle();
    applyStimulus(4'b1000, vec, 1'b1, 1'b0, '0, '1);
    advanceCycle();
    for (int i = 0; i < 4; i++) begin
      vec[0 +: CMD_W] = randCmd();
      applyStimulus(4'b0001, vec, 1'b1, 1'b1, randRes(), 4'b1101);
      checkCount++;
      if (ht_res_ready_o !== 1'b0 || ch_res_valid_o !== 4'b0010)
        $display("[TB] FAIL bp_stall %0d: got ready=%b valid=%b expected 0 0010", i, ht_res_ready_o, ch_res_valid_o);
      else passCount++;
      checkCount++;
      if (ch_cmd_ready_o !== 4'b0001 || ch_cmd_ready_o !== eReady)
        $display("[TB] FAIL bp_isolation %0d: got %b expected 0001", i, ch_cmd_ready_o);
      else passCount++;
      advanceCycle();
    end
    applyStimulus('0, '0, 1'b1, 1'b1, randRes(), 4'b1111);
    checkCount++;
    if (ht_res_ready_o !== 1'b1 || ch_res_valid_o !== 4'b0010)
      $display("[TB] FAIL bp_release: got ready=%b valid=%b expected 1 0010", ht_res_ready_o, ch_res_valid_o);
    else passCount++;
    advanceCycle();
    applyStimulus('0, '0, 1'b1, 1'b1, randRes(), 4'b1111);
    checkCount++;
    if (ch_res_valid_o !== 4'b1000) $display("[TB] FAIL bp_next_tag: got %b expected 1000", ch_res_valid_o);
    else passCount++;
    advanceCycle();
  endtask

  task automatic test_orphan();
    doReset();
    applyStimulus('0, '0, 1'b1, 1'b1, randRes(), '0);
    checkCount++;
    if (ht_res_ready_o !== 1'b1 || ch_res_valid_o !== 4'b0000 || err_orphan_o !== 1'b0)
      $display("[TB] FAIL orphan_cycle: got ready=%b valid=%b err=%b expected 1 0000 0", ht_res_ready_o, ch_res_valid_o, err_orphan_o);
    else passCount++;
    advanceCycle();
    for (int i = 0; i < 3; i++) begin
      applyStimulus('0, '0, 1'b1, 1'b0, '0, '1);
      checkCount++;
      if (err_orphan_o !== 1'b1 || err_orphan_o !== mErr)
        $display("[TB] FAIL orphan_sticky %0d: got %b expected 1", i, err_orphan_o);
      else passCount++;
      advanceCycle();
    end
  endtask

  task automatic test_reset_mid_burst();
    logic [CHANNELS*CMD_W-1:0] vec;
    for (int i = 0; i < 4; i++) begin
      for (int c = 0; c < CHANNELS; c++) vec[c*CMD_W +: CMD_W] = randCmd();
      applyStimulus(4'b1111, vec, 1'b1, 1'b0, '0, '1);
      advanceCycle();
    end
    @(negedge clk_i);
    checkCount++;
    if (outstanding_o !== CNT_W'(4) || ht_cmd_valid_o !== 1'b1 || err_orphan_o !== 1'b1)
      $display("[TB] FAIL burst_before_reset: got out=%0d v=%b err=%b expected 4 1 1", outstanding_o, ht_cmd_valid_o, err_orphan_o);
    else passCount++;
    #2;
    rst_n_i        = 1'b0;
    ch_cmd_valid_i = '0;
    #1;
    checkCount++;
    if (outstanding_o !== '0 || ht_cmd_valid_o !== 1'b0 || err_orphan_o !== 1'b0)
      $display("[TB] FAIL async_reset: got out=%0d v=%b err=%b expected 0 0 0", outstanding_o, ht_cmd_valid_o, err_orphan_o);
    else passCount++;
    @(negedge clk_i);
    mTags.delete();
    expCmdQ.delete();
    mRr  = 0;
    mErr = 1'b0;
    rst_n_i = 1'b1;
    applyStimulus(4'b0100, vec, 1'b1, 1'b0, '0, '1);
    checkCount++;
    if (ch_cmd_ready_o !== 4'b0100 || outstanding_o !== '0)
      $display("[TB] FAIL post_reset: got rdy=%b out=%0d expected 0100 0", ch_cmd_ready_o, outstanding_o);
    else passCount++;
    advanceCycle();
  endtask

  initial begin
    test_reset();
    test_single_channel();
    test_round_robin();
    test_fifo_full();
    test_stall();
    test_res_backpressure();
    test_orphan();
    test_reset_mid_burst();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
